integration_scheduler: RTL and testbench

INTEGRATION_SCHEDULER -- requirements
Module: integration_scheduler

---
 rtl/integration_scheduler.sv | 156 +++++++++++++++
 tb/tb_integration_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/integration_scheduler.sv
// Integration timing and correlator readout scheduler.
// Divides clki into a sample strobe and an end-of-integration strobe, and at
// the end of each integration streams a frame (sync byte followed by every
// accumulator, MSB byte first) to a byte-wide valid/ready transmitter.
module integration_scheduler #(
  parameter int         NUM_INPUTS      = 12,
  parameter int         NUM_CORRELATORS = NUM_INPUTS*(NUM_INPUTS-1)/2,
  parameter int         RESOLUTION      = 16,
  parameter int         SAMPLE_DIV      = 50,
  parameter int         INTEG_SAMPLES   = 100000,
  parameter logic [7:0] HEADER          = 8'hA5
) (
  input  logic                               clki,
  input  logic                               rsti_n,
  input  logic                               enable,
  output logic                               sample_clk_pulse,
  output logic                               integration_clk_pulse,
  output logic                               rd_en,
  output logic [$clog2(NUM_CORRELATORS)-1:0] rd_addr,
  input  logic [RESOLUTION-1:0]              rd_data,
  output logic [7:0]                         tx_data,
  output logic                               tx_valid,
  input  logic                               tx_ready,
  output logic                               busy,
  output logic                               overrun
);

  localparam int SW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int IW     = (INTEG_SAMPLES > 1) ? $clog2(INTEG_SAMPLES) : 1;
  localparam int AW     = $clog2(NUM_CORRELATORS);
  localparam int NBYTES = RESOLUTION / 8;
  localparam int BW     = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, LOAD, SEND} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [SW-1:0]         sample_cnt;
  logic [IW-1:0]         integ_cnt;
  logic [AW-1:0]         index;
  logic [RESOLUTION-1:0] shift_word;
  logic [BW-1:0]         byte_cnt;
  logic                  accept;
  logic                  last_byte;
  logic                  last_word;

  assign sample_clk_pulse      = enable && (sample_cnt == SW'(SAMPLE_DIV - 1));
  assign integration_clk_pulse = sample_clk_pulse && (integ_cnt == IW'(INTEG_SAMPLES - 1));
  assign accept                = tx_valid && tx_ready;
  assign last_byte             = (byte_cnt == BW'(1));
  assign last_word             = (index == AW'(NUM_CORRELATORS - 1));
  // The index only changes on the way into FETCH, so it doubles as a held rd_addr.
  assign rd_addr               = index;

  // Sample divider: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clki) begin
    if (!rsti_n || !enable) begin
      sample_cnt <= '0;
    end else if (sample_clk_pulse) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // Integration counter: advances once per sample strobe.
  always_ff @(posedge clki) begin
    if (!rsti_n || !enable) begin
      integ_cnt <= '0;
    end else if (sample_clk_pulse) begin
      integ_cnt <= integration_clk_pulse ? '0 : integ_cnt + 1'b1;
    end
  end

  // Readout state register.
  always_ff @(posedge clki) begin
    if (!rsti_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Readout next-state logic; a strobe seen outside IDLE never starts a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (integration_clk_pulse) state_nxt = HDR;
      HDR:     if (accept) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (accept && last_byte) state_nxt = last_word ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Readout outputs, decoded from the state so they are all zero in IDLE.
  always_comb begin
    rd_en    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b1;
    case (state)
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
      end
      FETCH:   rd_en = 1'b1;
      LOAD:    ;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_word[RESOLUTION-1 -: 8];
      end
      default: busy = 1'b0;
    endcase
  end

  // Word index and remaining-byte count for the frame in flight.
  always_ff @(posedge clki) begin
    if (!rsti_n) begin
      index    <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        HDR:  if (accept) index <= '0;
        LOAD: byte_cnt <= BW'(NBYTES);
        SEND: begin
          if (accept) begin
            byte_cnt <= byte_cnt - 1'b1;
            if (last_byte && !last_word) index <= index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Captured accumulator word, shifted up a byte per accepted transfer.
  always_ff @(posedge clki) begin
    if (state == LOAD) begin
      shift_word <= rd_data;
    end else if (state == SEND && accept) begin
      shift_word <= shift_word << 8;
    end
  end

  // Sticky flag: an integration ended while the previous frame was still out.
  always_ff @(posedge clki) begin
    if (!rsti_n) begin
      overrun <= 1'b0;
    end else if (integration_clk_pulse && busy) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_integration_scheduler.sv
// Directed bench for integration_scheduler with a 3-input, 16-bit build.
// Cycle c is the clock period that ends at the c-th rising edge after the
// last edge that samples reset low; outputs are recorded at its falling edge.
module tb_integration_scheduler;

  logic        clk;
  logic        rsti_n;
  logic        enable;
  logic        sample_clk_pulse;
  logic        integration_clk_pulse;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] snap [0:63];
  logic [7:0]  bytes [$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;
  logic [7:0]  exp_bytes [0:6] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

  integration_scheduler #(
    .NUM_INPUTS(3),
    .RESOLUTION(16),
    .SAMPLE_DIV(4),
    .INTEG_SAMPLES(3),
    .HEADER(8'hA5)
  ) dut (
    .clki(clk),
    .rsti_n(rsti_n),
    .enable(enable),
    .sample_clk_pulse(sample_clk_pulse),
    .integration_clk_pulse(integration_clk_pulse),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] acc_word(input logic [1:0] a);
    case (a)
      2'd0:    return 16'h1234;
      2'd1:    return 16'h5678;
      2'd2:    return 16'h9ABC;
      default: return 16'hDEAD;
    endcase
  endfunction

  // Accumulator memory: one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= acc_word(rd_addr);
  end

  // Transmitter side: collect accepted bytes and check holds across stalls.
  always @(negedge clk) begin
    if (prev_stall && rsti_n) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
    if (rsti_n && tx_valid && tx_ready) bytes.push_back(tx_data);
    prev_stall <= rsti_n && tx_valid && !tx_ready;
    prev_data  <= tx_data;
  end

  // mode 0: ready always, 1: ready on odd cycles, 2: ready from ready_from on.
  task automatic run_phase(input int mode, input int ready_from, input int en_lo_from,
                           input int en_lo_to, input int rst_at, input int last);
    rsti_n   = 1'b0;
    enable   = 1'b1;
    tx_ready = 1'b0;
    bytes.delete();
    for (int i = 0; i < 64; i++) snap[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 1;
    while (1) begin
      rsti_n = (cyc != rst_at);
      enable = !(cyc >= en_lo_from && cyc <= en_lo_to);
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = cyc[0];
        default: tx_ready = (cyc >= ready_from);
      endcase
      @(negedge clk);
      snap[cyc] = {sample_clk_pulse, integration_clk_pulse, rd_en, tx_valid,
                   busy, overrun, rd_addr, tx_data};
      if (cyc >= last) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pulse_mask(input int b, input int last);
    logic [31:0] m;
    m = '0;
    for (int c = 1; c <= last && c < 32; c++) m[c] = snap[c][b];
    return m;
  endfunction

  task automatic check_frame(input string tag, input int first);
    check({tag, "_len"}, bytes.size(), first + 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("%s_b%0d", tag, i),
            (first + i < bytes.size()) ? {24'd0, bytes[first + i]} : 32'hFFFF_FFFF,
            {24'd0, exp_bytes[i]});
    end
  endtask

  initial begin
    rsti_n   = 1'b0;
    enable   = 1'b0;
    tx_ready = 1'b0;

    // Free-running timing and a full frame with the transmitter always ready.
    run_phase(0, 0, 99, 99, 99, 30);
    check("reset_idle", snap[1], 16'h0000);
    check("p1_sample_mask", pulse_mask(15, 30), 32'h1111_1110);
    check("p1_integ_mask", pulse_mask(14, 30), 32'h0100_1000);
    check("p1_hdr", snap[13], 16'h18A5);
    check("p1_fetch0", snap[14], 16'h2800);
    check("p1_load0", snap[15], 16'h0800);
    check("p1_fetch2", snap[22], 16'h2A00);
    check("p1_busy_strobe", snap[24], 16'hDA9A);
    check("p1_overrun_set", snap[25], 16'h1EBC);
    check("p1_idle_hold", snap[26], 16'h0600);
    check_frame("p1", 0);

    // Transmitter ready only on odd cycles.
    run_phase(1, 0, 99, 99, 99, 34);
    check("p2_stall_b1", snap[17], 16'h1812);
    check("p2_stall_b2", snap[18], 16'h1834);
    check("p2_accept_b2", snap[19], 16'h1834);
    check("p2_idle", snap[33], 16'h0600);
    check_frame("p2", 0);

    // Transmitter held off for 20 cycles across an integration boundary.
    run_phase(2, 33, 99, 99, 99, 47);
    check("p3_hdr_strobe", snap[24], 16'hD8A5);
    check("p3_overrun", snap[25], 16'h1CA5);
    check("p3_idle", snap[46], 16'h0600);
    check("p3_no_second", snap[47], 16'h0600);
    check_frame("p3", 0);

    // Final byte accepted on the same cycle as an integration strobe.
    run_phase(2, 36, 99, 99, 99, 52);
    check("p4_last_byte", snap[48], 16'hDEBC);
    check("p4_no_restart", snap[49], 16'h0600);
    check("p4_stay_idle", snap[50], 16'h0600);
    check_frame("p4", 0);

    // enable low for cycles 6..9; first strobe four cycles after the last low cycle.
    run_phase(0, 0, 6, 9, 99, 24);
    check("p5_sample_mask", pulse_mask(15, 24), 32'h0022_2010);
    check("p5_integ_mask", pulse_mask(14, 24), 32'h0020_0000);

    // Reset asserted for one cycle right after the third byte of a frame.
    run_phase(2, 25, 99, 99, 30, 58);
    check("p6_pre_reset", snap[30], 16'h2D00);
    check("p6_after_reset", snap[31], 16'h0000);
    check("p6_no_early_strobe", {31'd0, snap[33][15]}, 32'd0);
    check("p6_first_strobe", {31'd0, snap[34][15]}, 32'd1);
    check("p6_new_hdr", snap[43], 16'h18A5);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("p6_partial_b%0d", i),
            (i < bytes.size()) ? {24'd0, bytes[i]} : 32'hFFFF_FFFF, {24'd0, exp_bytes[i]});
    end
    check_frame("p6", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
